lfsr_stream_checker: RTL and testbench

//  Receive-side counterpart of the 13-bit random-number LFSR (x^13 taps 12,3,2,0).

---
 rtl/lfsr_stream_checker_if.sv | 25 ++
 rtl/lfsr_stream_checker.sv | 110 +++++++++++
 tb/tb_lfsr_stream_checker.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/lfsr_stream_checker_if.sv
// Link between an LFSR bit-stream source and its receive-side checker.
// The master drives the stream and controls; the slave returns lock status and statistics.
interface lfsr_stream_checker_if #(
   parameter int CNT_W = 16
);
   logic             enable;
   logic             bit_in;
   logic             bit_valid;
   logic             clear_stats;
   logic             locked;
   logic             err_pulse;
   logic             lock_lost;
   logic [CNT_W-1:0] bit_count;
   logic [CNT_W-1:0] err_count;

   modport master (
      output enable, bit_in, bit_valid, clear_stats,
      input  locked, err_pulse, lock_lost, bit_count, err_count
   );

   modport slave (
      input  enable, bit_in, bit_valid, clear_stats,
      output locked, err_pulse, lock_lost, bit_count, err_count
   );
endinterface

// File: rtl/lfsr_stream_checker.sv
// Receive-side checker for the 13-bit LFSR stream (x^13, taps 12,3,2,0): self-seeds
// from 13 received bits, then predicts every later bit and tracks errors and lock.
module lfsr_stream_checker #(
   parameter int CNT_W       = 16,
   parameter int WINDOW      = 64,
   parameter int LOSS_THRESH = 4
) (
   input logic                   clock,
   input logic                   reset,
   lfsr_stream_checker_if.slave  link
);
   localparam int WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
   localparam int ERR_W = $clog2(LOSS_THRESH + 1);

   typedef enum logic {SEED, CHECK} state_t;

   state_t           state_reg;
   logic [12:0]      shreg_reg;
   logic [3:0]       seed_cnt_reg;
   logic [WIN_W-1:0] win_cnt_reg;
   logic [ERR_W-1:0] win_err_reg;
   logic             err_pulse_reg;
   logic             lock_lost_reg;
   logic [CNT_W-1:0] bit_count_reg;
   logic [CNT_W-1:0] err_count_reg;

   function automatic logic fb(input logic [12:0] s);
      return s[12] ^ s[3] ^ s[2] ^ s[0];
   endfunction

   logic [12:0]  seed_next;
   logic         exp_bit;
   logic         mis;
   logic [ERR_W:0] win_err_next;

   assign seed_next    = {shreg_reg[11:0], link.bit_in};
   assign exp_bit      = fb(shreg_reg);
   assign mis          = link.bit_in ^ exp_bit;
   assign win_err_next = {1'b0, win_err_reg} + {{ERR_W{1'b0}}, mis};

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg     <= SEED;
         shreg_reg     <= '0;
         seed_cnt_reg  <= '0;
         win_cnt_reg   <= '0;
         win_err_reg   <= '0;
         err_pulse_reg <= 1'b0;
         lock_lost_reg <= 1'b0;
         bit_count_reg <= '0;
         err_count_reg <= '0;
      end else begin
         err_pulse_reg <= 1'b0;
         lock_lost_reg <= 1'b0;
         if (!link.enable) begin
            state_reg    <= SEED;
            seed_cnt_reg <= '0;
            shreg_reg    <= '0;
            win_cnt_reg  <= '0;
            win_err_reg  <= '0;
         end else if (link.bit_valid) begin
            if (state_reg == SEED) begin
               shreg_reg <= seed_next;
               if (seed_cnt_reg == 4'd12) begin
                  // An all-zero seed is the LFSR's lock-up state, so keep seeding.
                  seed_cnt_reg <= '0;
                  if (seed_next != 13'd0) begin
                     state_reg   <= CHECK;
                     win_cnt_reg <= '0;
                     win_err_reg <= '0;
                  end
               end else begin
                  seed_cnt_reg <= seed_cnt_reg + 4'd1;
               end
            end else begin
               shreg_reg     <= {shreg_reg[11:0], exp_bit};
               err_pulse_reg <= mis;
               if (bit_count_reg != '1)
                  bit_count_reg <= bit_count_reg + 1'b1;
               if (mis && (err_count_reg != '1))
                  err_count_reg <= err_count_reg + 1'b1;
               if (win_err_next >= (ERR_W+1)'(LOSS_THRESH)) begin
                  state_reg     <= SEED;
                  lock_lost_reg <= 1'b1;
                  seed_cnt_reg  <= '0;
                  shreg_reg     <= '0;
                  win_cnt_reg   <= '0;
                  win_err_reg   <= '0;
               end else if (win_cnt_reg == WIN_W'(WINDOW - 1)) begin
                  win_cnt_reg <= '0;
                  win_err_reg <= '0;
               end else begin
                  win_cnt_reg <= win_cnt_reg + 1'b1;
                  win_err_reg <= win_err_next[ERR_W-1:0];
               end
            end
         end
         if (link.clear_stats) begin
            bit_count_reg <= '0;
            err_count_reg <= '0;
         end
      end
   end

   assign link.locked    = (state_reg == CHECK);
   assign link.err_pulse = err_pulse_reg;
   assign link.lock_lost = lock_lost_reg;
   assign link.bit_count = bit_count_reg;
   assign link.err_count = err_count_reg;
endmodule

// File: tb/tb_lfsr_stream_checker.sv
// Directed bench for lfsr_stream_checker: golden 13-bit LFSR source, injected bit errors,
// seeding corner cases, gapped stream, stats clear and asynchronous reset.
module tb_lfsr_stream_checker;
   logic clock;
   logic reset;
   int   n_cmp;
   int   n_bad;
   int   pulse_n;
   int   lost_n;
   int   pulse_base;
   int   lost_base;
   logic [12:0] gen_state;

   lfsr_stream_checker_if #(.CNT_W(16)) link ();

   lfsr_stream_checker #(
      .CNT_W(16),
      .WINDOW(64),
      .LOSS_THRESH(4)
   ) dut (
      .clock (clock),
      .reset (reset),
      .link  (link)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Pulse tallies are only ever read as differences against a snapshot.
   initial begin
      pulse_n = 0;
      lost_n  = 0;
   end
   always @(negedge clock) begin
      if (link.err_pulse === 1'b1) pulse_n++;
      if (link.lock_lost === 1'b1) lost_n++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
      n_cmp++;
      if (got !== expv) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, expv);
      end else begin
         $display("ok   %s = %0d", tag, got);
      end
   endtask

   task automatic step(input logic b, input logic v, input logic clr);
      link.bit_in      = b;
      link.bit_valid   = v;
      link.clear_stats = clr;
      @(posedge clock);
      #1;
      link.bit_valid   = 1'b0;
      link.clear_stats = 1'b0;
   endtask

   // Emits n stream bits from the golden generator; inv flips each emitted bit.
   task automatic gen_send(input int n, input logic inv, input logic gaps);
      logic nb;
      for (int i = 0; i < n; i++) begin
         nb = gen_state[12] ^ gen_state[3] ^ gen_state[2] ^ gen_state[0];
         gen_state = {gen_state[11:0], nb};
         if (gaps && ($urandom_range(0, 1) == 1)) step(1'b0, 1'b0, 1'b0);
         step(nb ^ inv, 1'b1, 1'b0);
      end
   endtask

   task automatic do_reset();
      reset            = 1'b1;
      link.enable      = 1'b1;
      link.bit_in      = 1'b0;
      link.bit_valid   = 1'b0;
      link.clear_stats = 1'b0;
      @(posedge clock);
      @(posedge clock);
      #1;
      reset      = 1'b0;
      gen_state  = 13'h000F;
      pulse_base = pulse_n;
      lost_base  = lost_n;
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;

      // 1: clean stream, lock timing and counts
      do_reset();
      check("rst_locked", 32'(link.locked), 0);
      check("rst_err_pulse", 32'(link.err_pulse), 0);
      check("rst_lock_lost", 32'(link.lock_lost), 0);
      check("rst_bit_count", 32'(link.bit_count), 0);
      check("rst_err_count", 32'(link.err_count), 0);
      gen_send(12, 1'b0, 1'b0);
      check("t1_locked_after12", 32'(link.locked), 0);
      gen_send(1, 1'b0, 1'b0);
      check("t1_locked_after13", 32'(link.locked), 1);
      check("t1_bit_count_at_lock", 32'(link.bit_count), 0);
      gen_send(100, 1'b0, 1'b0);
      check("t1_bit_count", 32'(link.bit_count), 100);
      check("t1_err_count", 32'(link.err_count), 0);
      check("t1_pulses", 32'(pulse_n - pulse_base + lost_n - lost_base), 0);

      // 2: single inverted bit #50
      do_reset();
      gen_send(13, 1'b0, 1'b0);
      gen_send(49, 1'b0, 1'b0);
      gen_send(1, 1'b1, 1'b0);
      check("t2_err_pulse_on", 32'(link.err_pulse), 1);
      gen_send(1, 1'b0, 1'b0);
      check("t2_err_pulse_off", 32'(link.err_pulse), 0);
      gen_send(49, 1'b0, 1'b0);
      check("t2_bit_count", 32'(link.bit_count), 100);
      check("t2_err_count", 32'(link.err_count), 1);
      check("t2_locked", 32'(link.locked), 1);
      check("t2_pulse_cycles", 32'(pulse_n - pulse_base), 1);

      // 3: four errors in one window force loss of lock
      do_reset();
      gen_send(13, 1'b0, 1'b0);
      gen_send(5, 1'b0, 1'b0);
      gen_send(1, 1'b1, 1'b0);
      gen_send(2, 1'b0, 1'b0);
      gen_send(2, 1'b1, 1'b0);
      gen_send(3, 1'b0, 1'b0);
      check("t3_locked_before", 32'(link.locked), 1);
      gen_send(1, 1'b1, 1'b0);
      check("t3_lock_lost", 32'(link.lock_lost), 1);
      check("t3_locked_after", 32'(link.locked), 0);
      check("t3_err_count", 32'(link.err_count), 4);
      check("t3_bit_count", 32'(link.bit_count), 14);
      step(1'b0, 1'b0, 1'b0);
      check("t3_lock_lost_off", 32'(link.lock_lost), 0);
      gen_send(13, 1'b0, 1'b0);
      check("t3_relocked", 32'(link.locked), 1);
      check("t3_lost_pulses", 32'(lost_n - lost_base), 1);

      // 4: three errors either side of a window boundary keep lock
      do_reset();
      gen_send(13, 1'b0, 1'b0);
      gen_send(61, 1'b0, 1'b0);
      gen_send(6, 1'b1, 1'b0);
      gen_send(61, 1'b0, 1'b0);
      check("t4_locked", 32'(link.locked), 1);
      check("t4_err_count", 32'(link.err_count), 6);
      check("t4_bit_count", 32'(link.bit_count), 128);
      check("t4_lost_pulses", 32'(lost_n - lost_base), 0);

      // 5: all-zero seed is rejected, seeding restarts
      do_reset();
      for (int i = 0; i < 13; i++) step(1'b0, 1'b1, 1'b0);
      check("t5_zero_seed_locked", 32'(link.locked), 0);
      gen_send(12, 1'b0, 1'b0);
      check("t5_locked_after12", 32'(link.locked), 0);
      gen_send(1, 1'b0, 1'b0);
      check("t5_locked_after13", 32'(link.locked), 1);
      check("t5_bit_count", 32'(link.bit_count), 0);

      // 6: gapped stream, clear on an error cycle, asynchronous reset
      do_reset();
      gen_send(113, 1'b0, 1'b1);
      check("t6_bit_count", 32'(link.bit_count), 100);
      check("t6_err_count", 32'(link.err_count), 0);
      check("t6_locked", 32'(link.locked), 1);
      begin
         logic nb;
         nb = gen_state[12] ^ gen_state[3] ^ gen_state[2] ^ gen_state[0];
         gen_state = {gen_state[11:0], nb};
         step(~nb, 1'b1, 1'b1);
      end
      check("t6_clear_bit_count", 32'(link.bit_count), 0);
      check("t6_clear_err_count", 32'(link.err_count), 0);
      check("t6_clear_err_pulse", 32'(link.err_pulse), 1);
      gen_send(5, 1'b0, 1'b0);
      check("t6_count_resumes", 32'(link.bit_count), 5);
      #2;
      reset = 1'b1;
      #1;
      check("t6_arst_locked", 32'(link.locked), 0);
      check("t6_arst_bit_count", 32'(link.bit_count), 0);
      check("t6_arst_err_count", 32'(link.err_count), 0);
      @(posedge clock);
      #1;
      reset = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
